// File: rtl/config_loader_pkg.sv
// Shared types and constants for the serial config-chain loader and its config store.
// The chain carries a clock-config field followed by the symmetric coefficient field.
package config_loader_pkg;

    localparam int CLK_CFG_W      = 2;
    localparam int SYM_COEFF_W    = 3;
    localparam int SHIFT_REG_SIZE = CLK_CFG_W + SYM_COEFF_W;

    // Value the config store takes on its own reset.
    localparam logic [SHIFT_REG_SIZE-1:0] CFG_DEFAULT = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } loader_state_e;

endpackage

// File: rtl/config_loader_strobe_gen.sv
// Shift strobe generator: 1-cycle strobe every StrobeDiv enabled cycles; sync clear restarts the count.
// Combinational strobe from the registered divider; no backpressure, the count only advances while enabled.
module shift_strobe_gen #(
    parameter int StrobeDiv = 1
) (
    input  logic clk,
    input  logic resetN,
    input  logic i_clr,
    input  logic i_en,
    output logic o_strobe
);

    localparam int DIV_W = (StrobeDiv > 1) ? $clog2(StrobeDiv) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(StrobeDiv - 1);

    logic [DIV_W-1:0] r_divCnt;
    logic             w_wrap;

    assign w_wrap   = (r_divCnt == DIV_LAST);
    assign o_strobe = i_en && w_wrap;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_divCnt <= '0;
        end else if (i_clr) begin
            r_divCnt <= '0;
        end else if (i_en) begin
            r_divCnt <= w_wrap ? '0 : r_divCnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/config_loader.sv
// Loads a parallel word MSB-first into the serial config chain, captures its old contents, optional verify pass.
// doneValid at accept + passes*N*StrobeDiv + 1; cfgReady low from accept until the cycle after doneValid.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int ShiftRegSize = SHIFT_REG_SIZE,
    parameter int StrobeDiv    = 1
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    cfgValid,
    output logic                    cfgReady,
    input  logic [ShiftRegSize-1:0] cfgData,
    input  logic                    cfgVerify,
    output logic                    serialEn,
    output logic                    serialIn,
    input  logic                    serialOut,
    output logic                    doneValid,
    output logic [ShiftRegSize-1:0] prevData,
    output logic                    verifyErr,
    output logic                    busy
);

    localparam int BIT_W = $clog2(ShiftRegSize + 1);
    localparam int ISS_W = $clog2(2 * ShiftRegSize + 1);

    loader_state_e           r_state;
    logic                    r_cfgReady;
    logic                    r_serialEn;
    logic                    r_serialIn;
    logic                    r_doneValid;
    logic [ShiftRegSize-1:0] r_prevData;
    logic                    r_verifyErr;
    logic [ShiftRegSize-1:0] r_txShift;
    logic [ShiftRegSize-2:0] r_rxShift;
    logic [ShiftRegSize-1:0] r_expected;
    logic                    r_verify;
    logic [BIT_W-1:0]        r_bitCnt;
    logic [ISS_W-1:0]        r_issCnt;

    logic                    w_accept;
    logic                    w_strobeEn;
    logic                    w_strobe;
    logic                    w_lastBit;
    logic [ISS_W-1:0]        w_issTarget;
    logic [ShiftRegSize-1:0] w_rxNext;

    assign w_accept    = cfgValid && r_cfgReady;
    assign w_issTarget = r_verify ? ISS_W'(2 * ShiftRegSize) : ISS_W'(ShiftRegSize);
    // Strobes are issued for both passes back to back; the sampling side lags one cycle behind.
    assign w_strobeEn  = ((r_state == ST_LOAD) || (r_state == ST_VERIFY)) && (r_issCnt < w_issTarget);
    assign w_rxNext    = {r_rxShift, serialOut};
    assign w_lastBit   = r_serialEn && (r_bitCnt == BIT_W'(ShiftRegSize - 1));

    shift_strobe_gen #(
        .StrobeDiv (StrobeDiv)
    ) u_strobe (
        .clk      (clk),
        .resetN   (resetN),
        .i_clr    (w_accept),
        .i_en     (w_strobeEn),
        .o_strobe (w_strobe)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state     <= ST_IDLE;
            r_cfgReady  <= 1'b1;
            r_serialEn  <= 1'b0;
            r_serialIn  <= 1'b0;
            r_doneValid <= 1'b0;
            r_prevData  <= '0;
            r_verifyErr <= 1'b0;
            r_txShift   <= '0;
            r_rxShift   <= '0;
            r_expected  <= '0;
            r_verify    <= 1'b0;
            r_bitCnt    <= '0;
            r_issCnt    <= '0;
        end else begin
            r_doneValid <= 1'b0;
            r_serialEn  <= w_strobe;
            r_serialIn  <= w_strobe & r_txShift[ShiftRegSize-1];
            // Rotating rather than zero-filling leaves the expected word in place for the verify pass.
            if (w_strobe) begin
                r_txShift <= {r_txShift[ShiftRegSize-2:0], r_txShift[ShiftRegSize-1]};
                r_issCnt  <= r_issCnt + ISS_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_txShift  <= cfgData;
                        r_expected <= cfgData;
                        r_verify   <= cfgVerify;
                        r_rxShift  <= '0;
                        r_bitCnt   <= '0;
                        r_issCnt   <= '0;
                        r_cfgReady <= 1'b0;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD, ST_VERIFY: begin
                    if (r_serialEn) begin
                        r_rxShift <= w_rxNext[ShiftRegSize-2:0];
                        r_bitCnt  <= r_bitCnt + BIT_W'(1);
                    end
                    if (w_lastBit) begin
                        r_bitCnt <= '0;
                        if (r_state == ST_LOAD) begin
                            r_prevData <= w_rxNext;
                        end else begin
                            r_verifyErr <= (w_rxNext != r_expected);
                        end
                        if ((r_state == ST_LOAD) && r_verify) begin
                            r_state <= ST_VERIFY;
                        end else begin
                            r_state     <= ST_DONE;
                            r_doneValid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_cfgReady <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cfgReady  = r_cfgReady;
    assign busy      = ~r_cfgReady;
    assign serialEn  = r_serialEn;
    assign serialIn  = r_serialIn;
    assign doneValid = r_doneValid;
    assign prevData  = r_prevData;
    assign verifyErr = r_verifyErr;

endmodule

// File: tb/tb_config_loader.sv
// Bench: two loaders (StrobeDiv 1 and 3), each driving a behavioural config store reset by ~resetN.
module tb_config_loader;
    import config_loader_pkg::*;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    // StrobeDiv = 1 instance
    logic       v1, vf1, r1, en1, sin1, sout1, done1, err1, busy1, stuck;
    logic [4:0] d1, prev1, store1;
    // StrobeDiv = 3 instance
    logic       v3, vf3, r3, en3, sin3, sout3, done3, err3, busy3;
    logic [4:0] d3, prev3, store3;

    config_loader #(.ShiftRegSize(5), .StrobeDiv(1)) dut (
        .clk(clk), .resetN(resetN), .cfgValid(v1), .cfgReady(r1), .cfgData(d1), .cfgVerify(vf1),
        .serialEn(en1), .serialIn(sin1), .serialOut(sout1), .doneValid(done1), .prevData(prev1),
        .verifyErr(err1), .busy(busy1));

    config_loader #(.ShiftRegSize(5), .StrobeDiv(3)) dut3 (
        .clk(clk), .resetN(resetN), .cfgValid(v3), .cfgReady(r3), .cfgData(d3), .cfgVerify(vf3),
        .serialEn(en3), .serialIn(sin3), .serialOut(sout3), .doneValid(done3), .prevData(prev3),
        .verifyErr(err3), .busy(busy3));

    // Config stores: shift left on serialEn, MSB fed back.
    always @(posedge clk) begin
        if (!resetN) store1 <= CFG_DEFAULT;
        else if (en1) store1 <= {store1[3:0], sin1};
        if (!resetN) store3 <= CFG_DEFAULT;
        else if (en3) store3 <= {store3[3:0], sin3};
    end
    assign sout1 = stuck ? 1'b0 : store1[4];
    assign sout3 = store3[4];

    typedef struct {
        logic [4:0] prev;
        logic       err;
        logic [4:0] store;
        int         done_k;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations from the last do_op (k = cycles after the accept edge)
    int         obs_pk[$];
    logic [9:0] obs_bits;
    int         obs_done_k, obs_done_cnt, obs_ready_k, obs_sin_bad;

    task automatic do_op(input bit sel, input logic [4:0] d, input logic vfy);
        logic s_en, s_sin, s_done, s_rdy;
        @(negedge clk);
        if (sel) begin v3 = 1'b1; d3 = d; vf3 = vfy; end
        else     begin v1 = 1'b1; d1 = d; vf1 = vfy; end
        @(posedge clk);
        #1;
        v1 = 1'b0; v3 = 1'b0;
        obs_pk.delete();
        obs_bits = '0; obs_done_k = -1; obs_done_cnt = 0; obs_ready_k = -1; obs_sin_bad = 0;
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            s_en   = sel ? en3 : en1;
            s_sin  = sel ? sin3 : sin1;
            s_done = sel ? done3 : done1;
            s_rdy  = sel ? r3 : r1;
            if (s_en) begin
                obs_pk.push_back(k);
                obs_bits = {obs_bits[8:0], s_sin};
            end else if (s_sin) begin
                obs_sin_bad++;
            end
            if (s_done) begin
                obs_done_cnt++;
                if (obs_done_k < 0) obs_done_k = k;
            end
            if (s_rdy) begin
                obs_ready_k = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (r1 !== 1'b1)       $display("FAIL reset_ready got %b want 1", r1); else n_pass++;
        n_checks++; if (busy1 !== 1'b0)    $display("FAIL reset_busy got %b want 0", busy1); else n_pass++;
        n_checks++; if (en1 !== 1'b0)      $display("FAIL reset_serialEn got %b want 0", en1); else n_pass++;
        n_checks++; if (sin1 !== 1'b0)     $display("FAIL reset_serialIn got %b want 0", sin1); else n_pass++;
        n_checks++; if (done1 !== 1'b0)    $display("FAIL reset_done got %b want 0", done1); else n_pass++;
        n_checks++; if (prev1 !== 5'b0)    $display("FAIL reset_prev got %b want 00000", prev1); else n_pass++;
        n_checks++; if (err1 !== 1'b0)     $display("FAIL reset_err got %b want 0", err1); else n_pass++;
        n_checks++; if (r3 !== 1'b1)       $display("FAIL reset_ready3 got %b want 1", r3); else n_pass++;
        n_checks++; if (en3 !== 1'b0)      $display("FAIL reset_serialEn3 got %b want 0", en3); else n_pass++;
        resetN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_no_verify();
        sb.push_back('{prev: 5'b11111, err: 1'b0, store: 5'b10110, done_k: 6});
        do_op(1'b0, 5'b10110, 1'b0);
        e = sb.pop_front();
        n_checks++; if (obs_pk.size() !== 5) $display("FAIL t1_pulses got %0d want 5", obs_pk.size()); else n_pass++;
        n_checks++; if (obs_pk.size() == 5 && (obs_pk[0] !== 1 || obs_pk[4] !== 5))
            $display("FAIL t1_pulse_span got %0d..%0d want 1..5", obs_pk[0], obs_pk[4]); else n_pass++;
        n_checks++; if (obs_bits[4:0] !== 5'b10110) $display("FAIL t1_serialIn got %b want 10110", obs_bits[4:0]); else n_pass++;
        n_checks++; if (obs_done_k !== e.done_k) $display("FAIL t1_done_at got %0d want %0d", obs_done_k, e.done_k); else n_pass++;
        n_checks++; if (obs_ready_k !== 7) $display("FAIL t1_ready_at got %0d want 7", obs_ready_k); else n_pass++;
        n_checks++; if (prev1 !== e.prev) $display("FAIL t1_prev got %b want %b", prev1, e.prev); else n_pass++;
        n_checks++; if (err1 !== e.err) $display("FAIL t1_err got %b want %b", err1, e.err); else n_pass++;
        n_checks++; if (store1 !== e.store) $display("FAIL t1_store got %b want %b", store1, e.store); else n_pass++;
    endtask

    task automatic test_load_verify();
        sb.push_back('{prev: 5'b10110, err: 1'b0, store: 5'b01001, done_k: 11});
        do_op(1'b0, 5'b01001, 1'b1);
        e = sb.pop_front();
        n_checks++; if (obs_pk.size() !== 10) $display("FAIL t2_pulses got %0d want 10", obs_pk.size()); else n_pass++;
        n_checks++; if (obs_bits !== 10'b0100101001) $display("FAIL t2_serialIn got %b want 0100101001", obs_bits); else n_pass++;
        n_checks++; if (obs_sin_bad !== 0) $display("FAIL t2_serialIn_idle got %0d want 0", obs_sin_bad); else n_pass++;
        n_checks++; if (obs_done_k !== e.done_k) $display("FAIL t2_done_at got %0d want %0d", obs_done_k, e.done_k); else n_pass++;
        n_checks++; if (obs_ready_k !== 12) $display("FAIL t2_ready_at got %0d want 12", obs_ready_k); else n_pass++;
        n_checks++; if (prev1 !== e.prev) $display("FAIL t2_prev got %b want %b", prev1, e.prev); else n_pass++;
        n_checks++; if (err1 !== e.err) $display("FAIL t2_err got %b want %b", err1, e.err); else n_pass++;
        n_checks++; if (store1 !== e.store) $display("FAIL t2_store got %b want %b", store1, e.store); else n_pass++;
    endtask

    task automatic test_verify_error();
        stuck = 1'b1;
        sb.push_back('{prev: 5'b00000, err: 1'b1, store: 5'b00001, done_k: 11});
        do_op(1'b0, 5'b00001, 1'b1);
        e = sb.pop_front();
        stuck = 1'b0;
        n_checks++; if (err1 !== e.err) $display("FAIL t3_err got %b want %b", err1, e.err); else n_pass++;
        n_checks++; if (obs_done_cnt !== 1) $display("FAIL t3_done_count got %0d want 1", obs_done_cnt); else n_pass++;
        n_checks++; if (obs_done_k !== e.done_k) $display("FAIL t3_done_at got %0d want %0d", obs_done_k, e.done_k); else n_pass++;
        n_checks++; if (prev1 !== e.prev) $display("FAIL t3_prev got %b want %b", prev1, e.prev); else n_pass++;
        n_checks++; if (store1 !== e.store) $display("FAIL t3_store got %b want %b", store1, e.store); else n_pass++;
    endtask

    task automatic test_strobe_div3();
        int bad_pos;
        sb.push_back('{prev: 5'b11111, err: 1'b0, store: 5'b11000, done_k: 16});
        do_op(1'b1, 5'b11000, 1'b0);
        e = sb.pop_front();
        bad_pos = 0;
        foreach (obs_pk[i]) if (obs_pk[i] !== 3 * (i + 1)) bad_pos++;
        n_checks++; if (obs_pk.size() !== 5) $display("FAIL t4_pulses got %0d want 5", obs_pk.size()); else n_pass++;
        n_checks++; if (bad_pos !== 0) $display("FAIL t4_pulse_spacing got %0d misplaced want 0", bad_pos); else n_pass++;
        n_checks++; if (obs_bits[4:0] !== 5'b11000) $display("FAIL t4_serialIn got %b want 11000", obs_bits[4:0]); else n_pass++;
        n_checks++; if (obs_done_k !== e.done_k) $display("FAIL t4_done_at got %0d want %0d", obs_done_k, e.done_k); else n_pass++;
        n_checks++; if (prev3 !== e.prev) $display("FAIL t4_prev got %b want %b", prev3, e.prev); else n_pass++;
        n_checks++; if (store3 !== e.store) $display("FAIL t4_store got %b want %b", store3, e.store); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int         ready_k, npulse, ndone;
        logic [9:0] bits;
        sb.push_back('{prev: 5'b00001, err: 1'b0, store: 5'b10011, done_k: 6});
        sb.push_back('{prev: 5'b10011, err: 1'b0, store: 5'b01110, done_k: 14});
        @(negedge clk);
        v1 = 1'b1; d1 = 5'b10011; vf1 = 1'b0;
        @(posedge clk);
        ready_k = -1; npulse = 0; ndone = 0; bits = '0;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) d1 = 5'b01110;
            if (en1) begin npulse++; bits = {bits[8:0], sin1}; end
            if (k == 3) begin
                n_checks++; if (r1 !== 1'b0) $display("FAIL t5_ready_busy got %b want 0", r1); else n_pass++;
                n_checks++; if (busy1 !== 1'b1) $display("FAIL t5_busy got %b want 1", busy1); else n_pass++;
            end
            if (r1 && ready_k < 0) ready_k = k;
            if (k == 8) begin
                n_checks++; if (r1 !== 1'b0) $display("FAIL t5_second_accept got ready=%b want 0", r1); else n_pass++;
                v1 = 1'b0;
            end
            if (done1) begin
                ndone++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_checks++; if (k !== e.done_k) $display("FAIL t5_done_at got %0d want %0d", k, e.done_k); else n_pass++;
                    n_checks++; if (prev1 !== e.prev) $display("FAIL t5_prev got %b want %b", prev1, e.prev); else n_pass++;
                    n_checks++; if (store1 !== e.store) $display("FAIL t5_store got %b want %b", store1, e.store); else n_pass++;
                end
            end
        end
        v1 = 1'b0;
        n_checks++; if (ready_k !== 7) $display("FAIL t5_ready_at got %0d want 7", ready_k); else n_pass++;
        n_checks++; if (ndone !== 2) $display("FAIL t5_done_count got %0d want 2", ndone); else n_pass++;
        n_checks++; if (npulse !== 10) $display("FAIL t5_pulses got %0d want 10", npulse); else n_pass++;
        n_checks++; if (bits !== 10'b1001101110) $display("FAIL t5_serialIn got %b want 1001101110", bits); else n_pass++;
        sb.delete();
    endtask

    task automatic test_reset_mid();
        int stray;
        @(negedge clk);
        v1 = 1'b1; d1 = 5'b00110; vf1 = 1'b0;
        @(posedge clk);
        #1 v1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (en1 !== 1'b1) $display("FAIL t6_second_pulse got %b want 1", en1); else n_pass++;
        resetN = 1'b0;
        @(negedge clk);
        n_checks++; if (en1 !== 1'b0 || sin1 !== 1'b0) $display("FAIL t6_serial got en=%b in=%b want 0 0", en1, sin1); else n_pass++;
        n_checks++; if (r1 !== 1'b1 || busy1 !== 1'b0) $display("FAIL t6_ready got ready=%b busy=%b want 1 0", r1, busy1); else n_pass++;
        n_checks++; if (done1 !== 1'b0 || err1 !== 1'b0) $display("FAIL t6_done_err got %b %b want 0 0", done1, err1); else n_pass++;
        n_checks++; if (prev1 !== 5'b0) $display("FAIL t6_prev got %b want 00000", prev1); else n_pass++;
        n_checks++; if (store1 !== 5'b11111) $display("FAIL t6_store_reset got %b want 11111", store1); else n_pass++;
        resetN = 1'b1;
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (en1) stray++;
        end
        n_checks++; if (stray !== 0) $display("FAIL t6_stray_pulses got %0d want 0", stray); else n_pass++;
        n_checks++; if (store1 !== 5'b11111) $display("FAIL t6_store_after got %b want 11111", store1); else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0; stuck = 1'b0;
        v1 = 1'b0; d1 = '0; vf1 = 1'b0;
        v3 = 1'b0; d3 = '0; vf3 = 1'b0;
        test_reset();
        test_load_no_verify();
        test_load_verify();
        test_verify_error();
        test_strobe_div3();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
